bw_threshold_ctrl: RTL and testbench
====================================

// Module: bw_threshold_ctrl
// PURPOSE
//  Configures the grayscale-to-B/W datapath: drives its enable_bw and bw_threshold inputs.
//  Accumulates the datapath's 8-bit gray output over each frame and divides sum by count to get the frame mean.
//  In auto mode, threshold = mean + signed offset, saturated to 0..255.
//  All config changes take effect only at frame boundaries (vsync), so no frame ever sees a mid-frame threshold change.
// PARAMETERS
//  CNT_W        19   pixel-count width (640x480 = 307200 fits); SUM_W = CNT_W+8 derived
//  INIT_THRESH  128  bw_threshold_out value after reset
// PORTS
//  clk               in   1      pixel clock
//  resetn            in   1      async active-low reset
//  vsync_pulse       in   1      1-cycle pulse, end of frame
//  pix_valid         in   1      gray_in carries an active pixel
//  gray_in           in   8      gray8_out of grayscale datapath
//  cfg_we            in   1      load cfg_* into shadow registers
//  cfg_auto          in   1      1 = auto threshold, 0 = manual
//  cfg_enable_bw     in   1      requested B/W enable
//  cfg_manual_thresh in   8      manual threshold
//  cfg_offset        in   8      signed two's-complement offset (auto mode)
//  enable_bw_out     out  1      to datapath enable_bw
//  bw_threshold_out  out  8      to datapath bw_threshold
//  mean_out          out  8      last computed frame mean
//  mean_valid        out  1      1-cycle pulse when mean_out updates
//  busy              out  1      high while in DIVIDE or UPDATE
// BEHAVIOUR
//  Reset values: enable_bw_out=0, bw_threshold_out=INIT_THRESH, mean_out=0, mean_valid=0, busy=0.
//  Reset: all state, shadows, accumulators and FSM cleared. Reset asserted mid-DIVIDE aborts; no update follows.
//  Shadow config: cfg_we writes shadows (last write wins). Outputs never read cfg_* directly.
//  Accumulate, every cycle with pix_valid=1:
//   - sum += gray_in; cnt += 1.
//   - At cnt = all-ones, both stop (saturate) until the next frame.
//  Simultaneous pix_valid and vsync_pulse: the pixel counts in the ending frame.
//  FSM states: ACCUM, DIVIDE, UPDATE.
//  ACCUM + vsync_pulse at cycle T:
//   - Snapshot sum/cnt into dividend/divisor; clear accumulators. The next frame accumulates in parallel.
//   - Apply shadows at T+1: enable_bw_out=cfg_enable_bw.
//   - Manual mode: bw_threshold_out=cfg_manual_thresh also at T+1.
//   - If cnt==0: stay in ACCUM. No mean_valid; mean_out and threshold unchanged.
//   - Else: go to DIVIDE.
//  DIVIDE:
//   - Restoring divide, 1 quotient bit per cycle, SUM_W cycles.
//   - Quotient <= 255 by construction; take the low 8 bits.
//   - Result is floor(sum/cnt).
//  UPDATE (1 cycle): mean_out=quotient.
//   - Auto mode: bw_threshold_out = sat(mean + sext(offset)), 10-bit signed add, clamp <0 to 0 and >255 to 255.
//   - mean_valid=1 for one cycle, coincident with the new mean_out and bw_threshold_out.
//   - Latency: vsync at T -> mean_valid at T+SUM_W+2 (T+29 for CNT_W=19). Then return to ACCUM.
//  vsync_pulse during DIVIDE/UPDATE:
//   - The divide in progress completes.
//   - The new frame's accumulators are cleared and its stats discarded.
//   - Shadows are not applied on that vsync.
//  Mode switch manual->auto: takes effect at the next vsync. The threshold holds the manual value until the first auto mean_valid.
// TESTING
//  1 Reset mid-DIVIDE -> outputs 0/128/0/0/0 immediately; no mean_valid afterwards.
//  2 Manual mode: cfg_we mid-frame (thresh 0x40, enable 1) -> outputs unchanged until vsync at T; 0x40/1 at T+1.
//  3 Auto mode, offset +5, pixels 10,20,30,41 -> mean_out=25 (floor 101/4); threshold 30; mean_valid at T+29.
//  4 Saturation: all pixels 250, offset +20 -> threshold 255. Mean 50, offset -128 -> threshold 0.
//  5 Frame with no pix_valid -> no mean_valid; mean_out and threshold hold previous values.
//  6 Pixel on vsync cycle:
//    - pix 100 with vsync, frame {100,100} -> mean 100; next frame starts from cnt 0.
//    - Second vsync 5 cycles later -> stats discarded, shadows not applied.

Source files
------------

// File: rtl/bw_threshold_ctrl_if.sv
// Pixel stream, shadow-config and datapath-control signals of bw_threshold_ctrl.
// master = pixel source / configuration host, slave = bw_threshold_ctrl.
interface bw_threshold_ctrl_if;
   logic       vsync_pulse;
   logic       pix_valid;
   logic [7:0] gray_in;
   logic       cfg_we;
   logic       cfg_auto;
   logic       cfg_enable_bw;
   logic [7:0] cfg_manual_thresh;
   logic [7:0] cfg_offset;
   logic       enable_bw_out;
   logic [7:0] bw_threshold_out;
   logic [7:0] mean_out;
   logic       mean_valid;
   logic       busy;

   modport master (
      output vsync_pulse, pix_valid, gray_in,
      output cfg_we, cfg_auto, cfg_enable_bw, cfg_manual_thresh, cfg_offset,
      input  enable_bw_out, bw_threshold_out, mean_out, mean_valid, busy
   );

   modport slave (
      input  vsync_pulse, pix_valid, gray_in,
      input  cfg_we, cfg_auto, cfg_enable_bw, cfg_manual_thresh, cfg_offset,
      output enable_bw_out, bw_threshold_out, mean_out, mean_valid, busy
   );
endinterface

// File: rtl/bw_threshold_ctrl.sv
// B/W threshold controller: accumulates per-frame gray statistics, divides
// sum by count to get the frame mean and drives enable_bw / bw_threshold of
// the grayscale datapath. Config only reaches the outputs at frame boundaries.
module bw_threshold_ctrl #(
   parameter int unsigned CNT_W       = 19,
   parameter logic [7:0]  INIT_THRESH = 8'd128
) (
   input  logic             clk,
   input  logic             resetn,
   bw_threshold_ctrl_if.slave bus
);

   localparam int unsigned SUM_W  = CNT_W + 8;
   localparam int unsigned ITER_W = $clog2(SUM_W);

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DIVIDE = 2'd1,
      UPDATE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // shadow configuration, written any time
   logic       sh_auto, sh_enable_bw;
   logic [7:0] sh_manual_thresh, sh_offset;

   // configuration applied at the last accepted frame boundary
   logic       act_auto;
   logic [7:0] act_offset;

   // per-frame accumulators
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic             take_pix;
   logic [SUM_W-1:0] sum_inc;
   logic [CNT_W-1:0] cnt_inc;

   // divider
   logic [SUM_W-1:0]  dq;        // dividend shifts out at the top, quotient shifts in at the bottom
   logic [CNT_W-1:0]  divisor;
   logic [CNT_W-1:0]  rem;
   logic [ITER_W-1:0] iter;
   logic [CNT_W:0]    rem_sh;
   logic [CNT_W:0]    rem_diff;
   logic              q_bit;
   logic [CNT_W-1:0]  rem_nxt;

   // outputs
   logic       enable_bw_q;
   logic [7:0] thresh_q;
   logic [7:0] mean_q;
   logic       mean_valid_q;
   logic       busy_c;
   logic       frame_end;
   logic signed [9:0] auto_sum;
   logic [7:0] auto_thresh;

   // pixel on the vsync cycle still belongs to the ending frame
   always_comb begin
      take_pix = bus.pix_valid && !(&cnt);
      sum_inc  = sum + (take_pix ? {{(SUM_W-8){1'b0}}, bus.gray_in} : '0);
      cnt_inc  = cnt + {{(CNT_W-1){1'b0}}, take_pix};
      frame_end = (state == ACCUM) && bus.vsync_pulse;
   end

   // one restoring-division step; borrow of the trial subtraction decides the quotient bit
   always_comb begin
      rem_sh   = {rem, dq[SUM_W-1]};
      rem_diff = rem_sh - {1'b0, divisor};
      q_bit    = ~rem_diff[CNT_W];
      rem_nxt  = q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
   end

   // auto threshold: mean plus sign-extended offset, clamped to 0..255
   always_comb begin
      auto_sum = $signed({2'b00, dq[7:0]}) + $signed({{2{act_offset[7]}}, act_offset});
      if (auto_sum[9])
         auto_thresh = 8'd0;
      else if (auto_sum[8])
         auto_thresh = 8'd255;
      else
         auto_thresh = auto_sum[7:0];
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= ACCUM;
      else
         state <= state_nxt;
   end

   // FSM next state and busy flag
   always_comb begin
      state_nxt = state;
      busy_c    = 1'b0;
      unique case (state)
         ACCUM: begin
            if (frame_end && (cnt_inc != '0))
               state_nxt = DIVIDE;
         end
         DIVIDE: begin
            busy_c = 1'b1;
            if (iter == '0)
               state_nxt = UPDATE;
         end
         UPDATE: begin
            busy_c    = 1'b1;
            state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // shadow config capture, last write wins
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sh_auto          <= 1'b0;
         sh_enable_bw     <= 1'b0;
         sh_manual_thresh <= '0;
         sh_offset        <= '0;
      end else if (bus.cfg_we) begin
         sh_auto          <= bus.cfg_auto;
         sh_enable_bw     <= bus.cfg_enable_bw;
         sh_manual_thresh <= bus.cfg_manual_thresh;
         sh_offset        <= bus.cfg_offset;
      end
   end

   // frame accumulators; any vsync clears them, stats from a busy-time frame are simply dropped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sum <= '0;
         cnt <= '0;
      end else if (bus.vsync_pulse) begin
         sum <= '0;
         cnt <= '0;
      end else begin
         sum <= sum_inc;
         cnt <= cnt_inc;
      end
   end

   // divider: load at accepted frame end, one quotient bit per DIVIDE cycle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dq      <= '0;
         divisor <= '0;
         rem     <= '0;
         iter    <= '0;
      end else if (frame_end) begin
         dq      <= sum_inc;
         divisor <= cnt_inc;
         rem     <= '0;
         iter    <= ITER_W'(SUM_W - 1);
      end else if (state == DIVIDE) begin
         dq   <= {dq[SUM_W-2:0], q_bit};
         rem  <= rem_nxt;
         iter <= iter - 1'b1;
      end
   end

   // datapath control outputs: shadows applied at frame end, mean/auto threshold at UPDATE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         enable_bw_q  <= 1'b0;
         thresh_q     <= INIT_THRESH;
         mean_q       <= '0;
         mean_valid_q <= 1'b0;
         act_auto     <= 1'b0;
         act_offset   <= '0;
      end else begin
         mean_valid_q <= 1'b0;
         if (frame_end) begin
            enable_bw_q <= sh_enable_bw;
            act_auto    <= sh_auto;
            act_offset  <= sh_offset;
            if (!sh_auto)
               thresh_q <= sh_manual_thresh;
         end
         if (state == UPDATE) begin
            mean_q       <= dq[7:0];
            mean_valid_q <= 1'b1;
            if (act_auto)
               thresh_q <= auto_thresh;
         end
      end
   end

   assign bus.enable_bw_out    = enable_bw_q;
   assign bus.bw_threshold_out = thresh_q;
   assign bus.mean_out         = mean_q;
   assign bus.mean_valid       = mean_valid_q;
   assign bus.busy             = busy_c;

endmodule

// File: tb/tb_bw_threshold_ctrl.sv
// Self-checking bench for bw_threshold_ctrl: directed scenarios plus random
// frames, compared every cycle against a frame-level reference model.
module tb_bw_threshold_ctrl;

   localparam int CNT_W   = 19;
   localparam int SUM_W   = CNT_W + 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk;
   logic resetn;

   bw_threshold_ctrl_if bus ();

   bw_threshold_ctrl #(
      .CNT_W       (CNT_W),
      .INIT_THRESH (8'd128)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int m_sum, m_cnt, m_pend, m_mean_pend;
   int sh_auto, sh_en, sh_man, sh_off;
   int a_auto, a_off;
   int e_en, e_th, e_mean, e_mv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int mean, input int off);
      int v;
      v = mean + off;
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   task automatic model_reset();
      m_sum = 0; m_cnt = 0; m_pend = 0; m_mean_pend = 0;
      sh_auto = 0; sh_en = 0; sh_man = 0; sh_off = 0;
      a_auto = 0; a_off = 0;
      e_en = 0; e_th = 128; e_mean = 0; e_mv = 0;
   endtask

   // frame-level behaviour at one clock edge; m_pend counts the busy cycles left
   task automatic model_edge(input bit vs, input bit pv, input int g, input bit we,
                             input int c_auto, input int c_en, input int c_man, input int c_off);
      int fs, fc;
      bit accept;
      e_mv   = 0;
      accept = (m_pend == 0);
      if (m_pend > 0) begin
         m_pend--;
         if (m_pend == 0) begin
            e_mean = m_mean_pend;
            e_mv   = 1;
            if (a_auto != 0) e_th = sat(e_mean, a_off);
         end
      end
      fs = m_sum;
      fc = m_cnt;
      if (pv && fc < CNT_MAX) begin
         fs += g;
         fc++;
      end
      if (vs) begin
         if (accept) begin
            e_en   = sh_en;
            a_auto = sh_auto;
            a_off  = sh_off;
            if (sh_auto == 0) e_th = sh_man;
            if (fc > 0) begin
               m_mean_pend = fs / fc;
               m_pend      = SUM_W + 1;
            end
         end
         m_sum = 0;
         m_cnt = 0;
      end else begin
         m_sum = fs;
         m_cnt = fc;
      end
      if (we) begin
         sh_auto = c_auto; sh_en = c_en; sh_man = c_man; sh_off = c_off;
      end
   endtask

   task automatic compare_all();
      check("enable_bw_out",    32'(bus.enable_bw_out),    e_en);
      check("bw_threshold_out", 32'(bus.bw_threshold_out), e_th);
      check("mean_out",         32'(bus.mean_out),         e_mean);
      check("mean_valid",       32'(bus.mean_valid),       e_mv);
      check("busy",             32'(bus.busy),             (m_pend > 0) ? 1 : 0);
   endtask

   // one clock cycle: inputs held from the previous negedge, outputs checked 1 time unit after posedge
   task automatic step(input bit vs, input bit pv, input logic [7:0] g);
      bus.vsync_pulse = vs;
      bus.pix_valid   = pv;
      bus.gray_in     = g;
      @(posedge clk);
      model_edge(vs, pv, int'(g), bus.cfg_we, int'(bus.cfg_auto), int'(bus.cfg_enable_bw),
                 int'(bus.cfg_manual_thresh), int'($signed(bus.cfg_offset)));
      #1;
      compare_all();
      @(negedge clk);
      bus.cfg_we      = 1'b0;
      bus.vsync_pulse = 1'b0;
      bus.pix_valid   = 1'b0;
   endtask

   // config write consumed by the next step
   task automatic cfg_set(input bit au, input bit en, input logic [7:0] man, input logic [7:0] off);
      bus.cfg_we            = 1'b1;
      bus.cfg_auto          = au;
      bus.cfg_enable_bw     = en;
      bus.cfg_manual_thresh = man;
      bus.cfg_offset        = off;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_en"},   32'(bus.enable_bw_out),    0);
      check({tag, "_th"},   32'(bus.bw_threshold_out), 128);
      check({tag, "_mean"}, 32'(bus.mean_out),         0);
      check({tag, "_mv"},   32'(bus.mean_valid),       0);
      check({tag, "_busy"}, 32'(bus.busy),             0);
   endtask

   int lat;
   int seen_mv;

   initial begin
      resetn                = 1'b0;
      bus.vsync_pulse       = 1'b0;
      bus.pix_valid         = 1'b0;
      bus.gray_in           = '0;
      bus.cfg_we            = 1'b0;
      bus.cfg_auto          = 1'b0;
      bus.cfg_enable_bw     = 1'b0;
      bus.cfg_manual_thresh = '0;
      bus.cfg_offset        = '0;
      model_reset();
      #12;
      check_reset_values("reset");
      @(negedge clk);
      resetn = 1'b1;

      // manual config written mid-frame only shows after the vsync
      repeat (3) step(1'b0, 1'b1, 8'($urandom));
      cfg_set(1'b0, 1'b1, 8'h40, 8'h00);
      step(1'b0, 1'b1, 8'd77);
      repeat (4) step(1'b0, 1'b1, 8'($urandom));
      check("man_hold_en", 32'(bus.enable_bw_out), 0);
      check("man_hold_th", 32'(bus.bw_threshold_out), 128);
      step(1'b1, 1'b0, 8'd0);
      check("man_apply_en", 32'(bus.enable_bw_out), 1);
      check("man_apply_th", 32'(bus.bw_threshold_out), 32'h40);
      idle(30);

      // auto mode, offset +5, pixels 10,20,30,41
      cfg_set(1'b1, 1'b1, 8'h40, 8'd5);
      step(1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0);
      check("auto_hold_manual_th", 32'(bus.bw_threshold_out), 32'h40);
      step(1'b0, 1'b1, 8'd10);
      step(1'b0, 1'b1, 8'd20);
      step(1'b0, 1'b1, 8'd30);
      step(1'b0, 1'b1, 8'd41);
      step(1'b1, 1'b0, 8'd0);
      lat = 0;
      for (int j = 1; j <= 40; j++) begin
         step(1'b0, 1'b0, 8'd0);
         if (bus.mean_valid === 1'b1 && lat == 0) lat = j + 1;
      end
      check("auto_latency", lat, 29);
      check("auto_mean", 32'(bus.mean_out), 25);
      check("auto_th", 32'(bus.bw_threshold_out), 30);

      // saturation high: all 250, offset +20
      cfg_set(1'b1, 1'b1, 8'h40, 8'd20);
      step(1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0);
      repeat (6) step(1'b0, 1'b1, 8'd250);
      step(1'b1, 1'b0, 8'd0);
      idle(30);
      check("sat_hi_mean", 32'(bus.mean_out), 250);
      check("sat_hi_th", 32'(bus.bw_threshold_out), 255);

      // empty frame: no mean_valid, outputs hold
      cfg_set(1'b1, 1'b1, 8'h40, 8'h80);
      step(1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0);
      seen_mv = 0;
      for (int j = 0; j < 30; j++) begin
         step(1'b0, 1'b0, 8'd0);
         if (bus.mean_valid === 1'b1) seen_mv++;
      end
      check("empty_no_mv", seen_mv, 0);
      check("empty_mean_hold", 32'(bus.mean_out), 250);
      check("empty_th_hold", 32'(bus.bw_threshold_out), 255);

      // saturation low: mean 50, offset -128
      step(1'b0, 1'b1, 8'd50);
      step(1'b0, 1'b1, 8'd40);
      step(1'b0, 1'b1, 8'd60);
      step(1'b1, 1'b0, 8'd0);
      idle(30);
      check("sat_lo_mean", 32'(bus.mean_out), 50);
      check("sat_lo_th", 32'(bus.bw_threshold_out), 0);

      // pixel on the vsync cycle, then a vsync while busy
      cfg_set(1'b0, 1'b1, 8'h22, 8'h00);
      step(1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0);
      idle(2);
      step(1'b0, 1'b1, 8'd100);
      step(1'b1, 1'b1, 8'd100);
      cfg_set(1'b0, 1'b0, 8'h11, 8'h00);
      step(1'b0, 1'b1, 8'd7);
      step(1'b0, 1'b1, 8'd7);
      step(1'b0, 1'b1, 8'd7);
      step(1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b0, 8'd0);
      check("busy_vs_en_kept", 32'(bus.enable_bw_out), 1);
      check("busy_vs_th_kept", 32'(bus.bw_threshold_out), 32'h22);
      idle(35);
      check("vs_pix_mean", 32'(bus.mean_out), 100);
      step(1'b0, 1'b1, 8'd20);
      step(1'b1, 1'b0, 8'd0);
      idle(30);
      check("after_discard_mean", 32'(bus.mean_out), 20);
      check("after_discard_th", 32'(bus.bw_threshold_out), 32'h11);
      check("after_discard_en", 32'(bus.enable_bw_out), 0);

      // random frames, config writes and vsync spacing
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            case ($urandom_range(0, 2))
               0:       cfg_set(1'($urandom), 1'($urandom), 8'($urandom), 8'h80);
               1:       cfg_set(1'($urandom), 1'($urandom), 8'($urandom), 8'h7F);
               default: cfg_set(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            endcase
         end
         step(1'($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom));
      end
      idle(30);

      // asynchronous reset in the middle of a divide
      repeat (3) step(1'b0, 1'b1, 8'd200);
      step(1'b1, 1'b0, 8'd0);
      idle(10);
      check("pre_reset_busy", 32'(bus.busy), 1);
      #3;
      resetn = 1'b0;
      #1;
      check_reset_values("reset_mid_div");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      seen_mv = 0;
      for (int j = 0; j < 40; j++) begin
         step(1'b0, 1'b0, 8'd0);
         if (bus.mean_valid === 1'b1) seen_mv++;
      end
      check("reset_no_mv", seen_mv, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
